// File: rtl/ex_defs_pkg.sv
// ex_defs: shared encodings for the EX stage (ALU ops, funct codes, FSM states, control bit positions)
package ex_defs;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSV   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    localparam int M_BRANCH      = 2;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 0;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ex_state_t;
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: shift-add multiplier, one partial product per cycle, low DW bits of the product
module ex_mul_iter #(
    parameter int DW = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          last,
    output logic [DW-1:0] product
);
    localparam int CW = $clog2(MUL_CYCLES);
    logic [DW-1:0] mcand, mplier, acc;
    logic [CW-1:0] cnt;
    logic          run;
    // product is the accumulator after this cycle's step, so it is final in the last cycle
    assign product = acc + (mplier[0] ? mcand : '0);
    assign busy    = run;
    assign last    = run && cnt == CW'(MUL_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            run    <= !last;
        end
    end
endmodule

// File: rtl/i_execute.sv
// i_execute: EX stage - ALU, branch-target add, dest select, iterative multiply and EX/MEM latch
module i_execute
    import ex_defs::*;
#(
    parameter int DW = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ID_EX_wb_ctlout,
    input  logic [2:0]    ID_EX_m_ctlout,
    input  logic          ID_EX_regdst,
    input  logic          ID_EX_alusrc,
    input  logic [1:0]    ID_EX_aluop,
    input  logic [DW-1:0] ID_EX_npc,
    input  logic [DW-1:0] ID_EX_readdat1,
    input  logic [DW-1:0] ID_EX_readdat2,
    input  logic [DW-1:0] ID_EX_sign_ext,
    input  logic [4:0]    ID_EX_instr_2016,
    input  logic [4:0]    ID_EX_instr_1511,
    output logic          ex_stall,
    output logic [1:0]    EX_MEM_wb_ctl,
    output logic [2:0]    EX_MEM_m_ctl,
    output logic [DW-1:0] EX_MEM_npc,
    output logic          EX_MEM_zero,
    output logic [DW-1:0] EX_MEM_alu_result,
    output logic [DW-1:0] EX_MEM_rdata2,
    output logic [4:0]    EX_MEM_write_reg
);
    ex_state_t     state, state_next;
    logic [5:0]    funct;
    logic [DW-1:0] op_b, sum, diff, rtype, alu_y, br_tgt, product, npc_q, opb_q;
    logic [4:0]    wr_sel, wr_q;
    logic [1:0]    wb_q;
    logic [2:0]    m_q;
    logic          is_mul, start, busy, last;

    assign funct  = ID_EX_sign_ext[5:0];
    assign op_b   = ID_EX_alusrc ? ID_EX_sign_ext : ID_EX_readdat2;
    assign sum    = ID_EX_readdat1 + op_b;
    assign diff   = ID_EX_readdat1 - op_b;
    assign br_tgt = ID_EX_npc + {ID_EX_sign_ext[DW-3:0], 2'b00};
    assign wr_sel = ID_EX_regdst ? ID_EX_instr_1511 : ID_EX_instr_2016;
    assign is_mul = ID_EX_aluop == ALUOP_FUNCT && funct == FUNCT_MUL;
    assign start  = state == IDLE && is_mul;

    always_comb begin
        case (funct)
            FUNCT_ADD: rtype = sum;
            FUNCT_SUB: rtype = diff;
            FUNCT_AND: rtype = ID_EX_readdat1 & op_b;
            FUNCT_OR:  rtype = ID_EX_readdat1 | op_b;
            FUNCT_SLT: rtype = {{(DW-1){1'b0}}, $signed(ID_EX_readdat1) < $signed(op_b)};
            default:   rtype = '0;
        endcase
    end

    assign alu_y = ID_EX_aluop == ALUOP_SUB ? diff : ID_EX_aluop == ALUOP_FUNCT ? rtype : sum;

    // stall drops in the final RUN cycle so the held mul leaves ID/EX instead of restarting
    always_comb begin
        state_next = state;
        ex_stall   = 1'b0;
        if (state == IDLE) begin
            state_next = is_mul ? RUN : IDLE;
            ex_stall   = rst_n && is_mul;
        end else begin
            state_next = last ? IDLE : RUN;
            ex_stall   = rst_n && !last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    ex_mul_iter #(.DW(DW), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(ID_EX_readdat1), .b(op_b),
        .busy(busy), .last(last), .product(product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q  <= '0;
            m_q   <= '0;
            wr_q  <= '0;
            npc_q <= '0;
            opb_q <= '0;
        end else if (start) begin
            wb_q  <= ID_EX_wb_ctlout;
            m_q   <= ID_EX_m_ctlout;
            wr_q  <= wr_sel;
            npc_q <= br_tgt;
            opb_q <= op_b;
        end
    end

    // everything other than a plain op or a finished multiply writes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_wb_ctl     <= '0;
            EX_MEM_m_ctl      <= '0;
            EX_MEM_npc        <= '0;
            EX_MEM_zero       <= 1'b0;
            EX_MEM_alu_result <= '0;
            EX_MEM_rdata2     <= '0;
            EX_MEM_write_reg  <= '0;
        end else if (!busy && !is_mul) begin
            EX_MEM_wb_ctl     <= ID_EX_wb_ctlout;
            EX_MEM_m_ctl      <= ID_EX_m_ctlout;
            EX_MEM_npc        <= br_tgt;
            EX_MEM_zero       <= alu_y == '0;
            EX_MEM_alu_result <= alu_y;
            EX_MEM_rdata2     <= ID_EX_readdat2;
            EX_MEM_write_reg  <= wr_sel;
        end else if (last) begin
            EX_MEM_wb_ctl     <= wb_q;
            EX_MEM_m_ctl      <= m_q;
            EX_MEM_npc        <= npc_q;
            EX_MEM_zero       <= product == '0;
            EX_MEM_alu_result <= product;
            EX_MEM_rdata2     <= opb_q;
            EX_MEM_write_reg  <= wr_q;
        end else begin
            EX_MEM_wb_ctl     <= '0;
            EX_MEM_m_ctl      <= '0;
            EX_MEM_npc        <= '0;
            EX_MEM_zero       <= 1'b0;
            EX_MEM_alu_result <= '0;
            EX_MEM_rdata2     <= '0;
            EX_MEM_write_reg  <= '0;
        end
    end
endmodule

// File: tb/tb_i_execute.sv
// tb_i_execute: directed steps with a scoreboard of expected EX/MEM contents per clock edge
module tb_i_execute;
    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] npc;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wb_in = '0;
    logic [2:0]  m_in = '0;
    logic        regdst = 1'b0;
    logic        alusrc = 1'b0;
    logic [1:0]  aluop = '0;
    logic [31:0] npc = '0, r1 = '0, r2 = '0, se = '0;
    logic [4:0]  rt = '0, rd = '0;
    logic        ex_stall;
    logic [1:0]  o_wb;
    logic [2:0]  o_m;
    logic [31:0] o_npc, o_alu, o_rd2;
    logic        o_zero;
    logic [4:0]  o_wr;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    i_execute dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_wb_ctlout(wb_in), .ID_EX_m_ctlout(m_in),
        .ID_EX_regdst(regdst), .ID_EX_alusrc(alusrc), .ID_EX_aluop(aluop),
        .ID_EX_npc(npc), .ID_EX_readdat1(r1), .ID_EX_readdat2(r2),
        .ID_EX_sign_ext(se), .ID_EX_instr_2016(rt), .ID_EX_instr_1511(rd),
        .ex_stall(ex_stall),
        .EX_MEM_wb_ctl(o_wb), .EX_MEM_m_ctl(o_m), .EX_MEM_npc(o_npc),
        .EX_MEM_zero(o_zero), .EX_MEM_alu_result(o_alu),
        .EX_MEM_rdata2(o_rd2), .EX_MEM_write_reg(o_wr)
    );

    function automatic exp_t obs();
        return '{o_wb, o_m, o_npc, o_zero, o_alu, o_rd2, o_wr};
    endfunction

    function automatic exp_t mk(logic [1:0] w, logic [2:0] m, logic [31:0] n,
                                logic [31:0] alu, logic [31:0] d2, logic [4:0] r);
        return '{w, m, n, alu == 32'd0, alu, d2, r};
    endfunction

    task automatic instr(input logic [1:0] w, input logic [2:0] m, input logic rdst,
                         input logic asrc, input logic [1:0] op, input logic [31:0] n,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                         input logic [4:0] t, input logic [4:0] d);
        wb_in = w; m_in = m; regdst = rdst; alusrc = asrc; aluop = op;
        npc = n; r1 = a; r2 = b; se = s; rt = t; rd = d;
    endtask

    task automatic chk_stall(input string tag, input logic e);
        tests++;
        assert (ex_stall === e) else begin
            fails++;
            $error("FAIL %s stall: got %b want %b", tag, ex_stall, e);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        exp_t o;
        o = obs();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s exmem: got %h want %h", tag, o, e);
        end
    endtask

    // one clock: check stall before the edge, then compare EX/MEM against the scoreboard head
    task automatic step(input string tag, input exp_t e, input logic st);
        #2;
        chk_stall(tag, st);
        q.push_back(e);
        @(posedge clk);
        #1;
        chk_out(tag, q.pop_front());
    endtask

    initial begin
        exp_t mul_res;
        @(negedge clk);
        chk_stall("reset", 1'b0);
        chk_out("reset", '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h10, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
        step("add", mk(2'b10, 3'b000, 32'h10 + 32'h80, 32'd12, 32'd7, 5'd3), 1'b0);

        instr(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h40, 32'h1234, 32'h1234, 32'hFFFFFFFE, 5'd5, 5'd6);
        step("beq", mk(2'b00, 3'b100, 32'h38, 32'd0, 32'h1234, 5'd5), 1'b0);

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
        step("slt_neg", mk(2'b10, 3'b000, 32'hA8, 32'd1, 32'd1, 5'd2), 1'b0);
        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd2);
        step("slt_swap", mk(2'b10, 3'b000, 32'hA8, 32'd0, 32'hFFFFFFFF, 5'd2), 1'b0);

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h9, 32'h4, 32'h22, 5'd1, 5'd7);
        step("sub", mk(2'b10, 3'b000, 32'h88, 32'd5, 32'h4, 5'd7), 1'b0);
        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd7);
        step("and", mk(2'b10, 3'b000, 32'h90, 32'hF000, 32'hFF00, 5'd7), 1'b0);
        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 32'h25, 5'd1, 5'd7);
        step("or", mk(2'b10, 3'b000, 32'h94, 32'hFFF0, 32'hFF00, 5'd7), 1'b0);

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h100, 32'd7, 32'hFFFFFFFD, 32'h18, 5'd4, 5'd8);
        mul_res = mk(2'b10, 3'b000, 32'h100 + 32'h60, 32'd7 * 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd8);
        for (int i = 0; i < 32; i++) step($sformatf("mul_bubble%0d", i), '0, 1'b1);
        step("mul_result", mul_res, 1'b0);
        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'd1, 32'h20, 5'd1, 5'd3);
        step("add_after_mul", mk(2'b10, 3'b000, 32'h80, 32'd2, 32'd1, 5'd3), 1'b0);

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd6, 32'd6, 32'h18, 5'd4, 5'd8);
        for (int i = 0; i < 11; i++) step($sformatf("abort_bubble%0d", i), '0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_stall("mid_reset", 1'b0);
        chk_out("mid_reset", '0);
        @(posedge clk);
        #1;
        chk_out("held_reset", '0);
        rst_n = 1'b1;
        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd2, 32'd3, 32'h20, 5'd1, 5'd3);
        step("add_after_reset", mk(2'b10, 3'b000, 32'h80, 32'd5, 32'd3, 5'd3), 1'b0);

        instr(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7, 32'h3F, 5'd1, 5'd3);
        step("unknown_funct", mk(2'b10, 3'b000, 32'hFC, 32'd0, 32'd7, 5'd3), 1'b0);
        instr(2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h20, 32'h100, 32'h55, 32'd8, 5'd4, 5'd12);
        step("lw", mk(2'b11, 3'b010, 32'h40, 32'h108, 32'h55, 5'd4), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i_execute.md
Name: i_execute

Overview:
- EX stage of the 5-stage MIPS-subset pipeline. Sits directly downstream of i_decode and upstream of the memory stage.
- Consumes ID/EX control and operands, then performs:
  - ALU operation
  - branch-target add
  - destination-register select
  - an iterative 32-cycle multiply
- Registers results into the EX/MEM pipeline latch and stalls upstream while a multiply is in flight.

Parameters:
- DW, 32, datapath width (fixed at 32; MIPS encoding assumed)
- MUL_CYCLES, 32, shift-add iterations per multiply (equals DW)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_EX_wb_ctlout  in  2  {reg_write, mem_to_reg}
- ID_EX_m_ctlout  in  3  {branch, mem_read, mem_write}
- ID_EX_regdst  in  1  1: rd, 0: rt
- ID_EX_alusrc  in  1  1: sign_ext operand, 0: readdat2
- ID_EX_aluop  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved (add)
- ID_EX_npc  in  32  PC+4 of this instruction
- ID_EX_readdat1  in  32  rs value
- ID_EX_readdat2  in  32  rt value
- ID_EX_sign_ext  in  32  sign-extended immediate (funct in [5:0])
- ID_EX_instr_2016  in  5  rt field
- ID_EX_instr_1511  in  5  rd field
- ex_stall  out  1  hold PC, IF/ID and ID/EX this cycle
- EX_MEM_wb_ctl  out  2  registered WB controls
- EX_MEM_m_ctl  out  3  registered M controls
- EX_MEM_npc  out  32  registered branch target
- EX_MEM_zero  out  1  registered result==0
- EX_MEM_alu_result  out  32  registered ALU/multiply result
- EX_MEM_rdata2  out  32  registered readdat2 (store data)
- EX_MEM_write_reg  out  5  registered destination register

Behaviour:
- Reset (async, rst_n=0): all EX_MEM_* outputs 0, state IDLE, counter 0. ex_stall evaluates to 0.
- Operand B = alusrc ? sign_ext : readdat2.
- ALU function:
  - aluop 00 → add
  - aluop 01 → sub
  - aluop 11 → add
  - aluop 10 → funct = sign_ext[5:0]:
    - 0x20 add; 0x22 sub; 0x24 and; 0x25 or
    - 0x2A slt: signed compare, result 1 or 0
    - 0x18 mul
    - any other funct → result 0
- Arithmetic is modulo 2^32; no overflow trap.
- Branch target = npc + (sign_ext << 2), wrapping at 32 bits.
- write_reg = regdst ? instr_1511 : instr_2016.
- Non-mul instruction: single-cycle. EX/MEM latches all results at the next edge; ex_stall=0.
- FSM states: IDLE, RUN.
  - IDLE, is_mul (aluop==10 && funct==0x18):
    - ex_stall=1.
    - At the edge: capture mcand=readdat1, mplier=operand B, acc=0, cnt=0, plus wb/m/write_reg/npc.
    - Go to RUN. EX/MEM loads a bubble (all fields 0).
  - RUN, each cycle:
    - acc_next = acc + (mplier[0] ? mcand : 0); mcand<<=1; mplier>>=1; cnt++.
    - ex_stall = (cnt != 31).
    - While cnt<31, EX/MEM loads a bubble.
  - RUN, cnt==31:
    - ex_stall=0.
    - At the edge: EX/MEM loads acc_next (low 32 bits of product), captured controls and write_reg; zero=(acc_next==0); rdata2 = captured operand B.
    - Go to IDLE.
- Multiply totals: 33 cycles occupancy, 32 stall cycles, 32 bubbles.
- Inputs are ignored in RUN. Upstream holds ID/EX stable under stall; the held mul is not re-detected because stall drops in the final RUN cycle, letting ID/EX advance.
- Back-to-back mul: the second mul is detected in the IDLE cycle immediately after completion; no gap cycles.
- Reset mid-RUN: abort immediately. No partial result is written; outputs return to 0.

Decomposition:
- Shared package/header ex_defs:
  - ALUOP_* encodings
  - FUNCT_ADD/SUB/AND/OR/SLT/MUL
  - EX state encoding (IDLE=0, RUN=1)
  - WB/M control bit positions
- One sub-module, ex_mul_iter:
  - Owns mcand/mplier/acc/cnt.
  - Interface: start, a, b → busy, last, product.
  - i_execute keeps the ALU, muxes, FSM glue and EX/MEM register.

Test Plan:
- add R-type:
  - Stimulus: readdat1=5, readdat2=7, aluop=10, funct=0x20, regdst=1, rd=3, wb=10.
  - Response: next edge alu_result=12, write_reg=3, zero=0, wb_ctl=10, ex_stall=0.
- beq taken:
  - Stimulus: aluop=01, readdat1=readdat2=0x1234, m_ctl=100, npc=0x40, sign_ext=0xFFFFFFFE.
  - Response: zero=1, alu_result=0, EX_MEM_npc=0x38.
- slt signed:
  - Stimulus: readdat1=0xFFFFFFFF, readdat2=1, funct=0x2A.
  - Response: alu_result=1; with operands swapped, result 0.
- mul:
  - Stimulus: readdat1=7, readdat2=0xFFFFFFFD, funct=0x18.
  - Response: ex_stall high exactly 32 cycles; 32 zero bubbles in EX/MEM; then alu_result=0xFFFFFFEB with original wb_ctl/write_reg; next instruction (add 1+1) gives 2 the following cycle.
- Reset mid-mul:
  - Stimulus: assert rst_n=0 at RUN cnt=10, release, then present add 2+3.
  - Response: all outputs 0 during reset, ex_stall=0, no product written; next edge alu_result=5.
- Unknown funct:
  - Stimulus: funct 0x3F, aluop=10, lw path aluop=00, alusrc=1, readdat1=0x100, sign_ext=8, m_ctl=010.
  - Response: result 0 for the unknown funct; lw path alu_result=0x108, write_reg=rt.
